bsg_ring_tracker: RTL
=====================

BSG_RING_TRACKER -- requirements
Module: bsg_ring_tracker

Interface
REQ-001 slots_p, default 8, ring depth in slots; SHALL be >= 2, and non-power-of-two values are legal.
REQ-002 max_enq_p, default 2, maximum slots reserved per cycle; SHALL satisfy 1 <= max_enq_p <= slots_p.
REQ-003 max_deq_p, default 2, maximum slots released per cycle; SHALL satisfy 1 <= max_deq_p <= slots_p.
REQ-004 Derived widths: ptr_width_lp = BSG_SAFE_CLOG2(slots_p); cnt_width_lp = clog2(slots_p+1).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 enq_v_i  in  1  enqueue (reserve) request.
REQ-008 enq_cnt_i  in  clog2(max_enq_p+1)  number of slots requested.
REQ-009 enq_accept_o  out  1  request accepted this cycle; combinational.
REQ-010 deq_v_i  in  1  dequeue (release) request.
REQ-011 deq_cnt_i  in  clog2(max_deq_p+1)  number of slots released.
REQ-012 deq_accept_o  out  1  release accepted this cycle; combinational.
REQ-013 flush_i  in  1  discard all occupied slots.
REQ-014 wptr_o  out  ptr_width_lp  registered write pointer (first free slot).
REQ-015 rptr_o  out  ptr_width_lp  registered read pointer (oldest occupied slot).
REQ-016 count_o  out  cnt_width_lp  registered occupancy.
REQ-017 full_o / empty_o  out  1 each  count_o == slots_p / count_o == 0.

Function
REQ-018 enq_accept_o SHALL equal enq_v_i & ~flush_i & (enq_cnt_i <= slots_p - count_r).
REQ-019 deq_accept_o SHALL equal deq_v_i & ~flush_i & (deq_cnt_i <= count_r).
REQ-020 Both acceptance checks SHALL use registered state only, with no same-cycle bypass between enqueue and dequeue.
REQ-021 A rejected request SHALL cause no state change, and partial acceptance SHALL NOT occur.
REQ-022 On accept, wptr SHALL update as wptr_n = (wptr_r + enq_cnt_i) mod slots_p; rptr SHALL update likewise with deq_cnt_i.
REQ-023 Pointer wrap SHALL be exact for non-power-of-two slots_p.
REQ-024 On accept, count_n SHALL equal count_r + (enq_accept_o ? enq_cnt_i : 0) - (deq_accept_o ? deq_cnt_i : 0).
REQ-025 The count_n computation SHALL use cnt_width_lp+1 bits internally and never go negative or exceed slots_p.
REQ-026 A request with count 0 and valid high SHALL be accepted and SHALL leave state unchanged.
REQ-027 Simultaneous accepted enqueue and dequeue SHALL both update in the same cycle.
REQ-028 When flush_i is high, on the next edge: rptr <= wptr_r, count <= 0, and wptr SHALL be held.
REQ-029 flush_i SHALL take priority over enqueue and dequeue.
REQ-030 All outputs except the two accept outputs SHALL be register outputs with 1-cycle update latency.
REQ-031 Simulation-only assertions SHALL flag count_r > slots_p and any input count exceeding its max parameter.

Reset
REQ-032 Asserting reset_i SHALL immediately, without a clock edge, force wptr_o = 0, rptr_o = 0, count_o = 0, empty_o = 1, full_o = 0.
REQ-033 During reset, enq_accept_o and deq_accept_o SHALL be 0.
REQ-034 Reset assertion mid-operation SHALL discard all occupancy.
REQ-035 The first state update after reset SHALL occur on the first rising edge after reset_i deasserts.

Structure
REQ-036 No shared package is required; widths SHALL be local parameters.
REQ-037 One sub-module, bsg_circular_ptr_ar, SHALL be instantiated twice (write and read).
REQ-038 bsg_circular_ptr_ar SHALL be a modulo-slots_p pointer with an add input and asynchronous active-high reset, outputting current and next pointer.
REQ-039 bsg_circular_ptr_ar SHALL use the power-of-two add-by-one shortcut and the parallel wrap/no-wrap compare otherwise.
REQ-040 The count register and acceptance logic SHALL reside in bsg_ring_tracker.

Verification (slots_p=6, max_enq_p=max_deq_p=3)
REQ-041 Reset: assert reset_i between edges -> outputs immediately wptr=rptr=0, count=0, empty=1, full=0.
REQ-042 Fill: enq 3, enq 3 -> count=6, full=1, wptr=0 (wrapped); then enq 1 -> enq_accept_o=0, state unchanged.
REQ-043 Wrap: with wptr=4 and count=2, enq 3 -> wptr=1, count=5; then deq 3 from rptr=2 -> rptr=5, count=2.
REQ-044 Simultaneous: count=6, enq 2 + deq 2 -> deq accepted, enq rejected, count=4.
REQ-045 Simultaneous: count=3, enq 3 + deq 3 -> both accepted, count=3.
REQ-046 Flush: rptr=2, wptr=5, count=3, flush_i with enq 1 -> enq_accept_o=0; next cycle rptr=5, wptr=5, count=0, empty=1.
REQ-047 Over-release: count=1, deq 2 -> deq_accept_o=0, count stays 1.

Source files
------------

// File: rtl/bsg_ring_tracker_pkg.sv
// Shared helpers for the ring tracker slice: width helpers used by the
// interface, the top and the circular pointer.
package bsg_ring_tracker_pkg;

    // clog2 that never returns 0, so a 1-slot ring still has a 1-bit pointer.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int count_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/bsg_ring_tracker_if.sv
// Reserve/release handshake and registered status of the ring tracker.
interface bsg_ring_tracker_if
#(
    parameter int slots_p   = 8,
    parameter int max_enq_p = 2,
    parameter int max_deq_p = 2
);
    import bsg_ring_tracker_pkg::*;

    localparam int ptr_width_lp = safe_clog2(slots_p);
    localparam int cnt_width_lp = count_width(slots_p);
    localparam int enq_width_lp = count_width(max_enq_p);
    localparam int deq_width_lp = count_width(max_deq_p);

    logic                    enq_v_i;
    logic [enq_width_lp-1:0] enq_cnt_i;
    logic                    enq_accept_o;
    logic                    deq_v_i;
    logic [deq_width_lp-1:0] deq_cnt_i;
    logic                    deq_accept_o;
    logic                    flush_i;
    logic [ptr_width_lp-1:0] wptr_o;
    logic [ptr_width_lp-1:0] rptr_o;
    logic [cnt_width_lp-1:0] count_o;
    logic                    full_o;
    logic                    empty_o;

    modport master (
        output enq_v_i, enq_cnt_i, deq_v_i, deq_cnt_i, flush_i,
        input  enq_accept_o, deq_accept_o, wptr_o, rptr_o, count_o, full_o, empty_o
    );

    modport slave (
        input  enq_v_i, enq_cnt_i, deq_v_i, deq_cnt_i, flush_i,
        output enq_accept_o, deq_accept_o, wptr_o, rptr_o, count_o, full_o, empty_o
    );

endinterface

// File: rtl/bsg_circular_ptr_ar.sv
// Modulo-slots_p pointer with a multi-step add input; exposes the current
// and the next pointer value.
module bsg_circular_ptr_ar
    import bsg_ring_tracker_pkg::*;
#(
    parameter int  slots_p      = 8,
    parameter int  max_add_p    = 1,
    localparam int ptr_width_lp = safe_clog2(slots_p),
    localparam int add_width_lp = count_width(max_add_p)
)
(
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [add_width_lp-1:0] add_i,
    output logic [ptr_width_lp-1:0] ptr_o,
    output logic [ptr_width_lp-1:0] ptr_n_o
);

    logic [ptr_width_lp-1:0] ptr_r;

    generate
        if ((slots_p & (slots_p - 1)) == 0) begin : g_pow2
            // Natural binary rollover is the modulo.
            assign ptr_n_o = ptr_r + ptr_width_lp'(add_i);
        end else begin : g_npow2
            logic [ptr_width_lp:0]   sum;
            logic [ptr_width_lp-1:0] ptr_wrap;

            // Both candidates are formed in parallel; the compare only selects.
            assign sum      = (ptr_width_lp+1)'(ptr_r) + (ptr_width_lp+1)'(add_i);
            assign ptr_wrap = ptr_width_lp'(sum - (ptr_width_lp+1)'(slots_p));
            assign ptr_n_o  = (sum >= (ptr_width_lp+1)'(slots_p)) ? ptr_wrap
                                                                  : sum[ptr_width_lp-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_n_o;
        end
    end

    assign ptr_o = ptr_r;

endmodule

// File: rtl/bsg_ring_tracker.sv
// Occupancy tracker for a circular buffer: all-or-nothing reservation and
// release of slot groups, plus flush of every occupied slot.
module bsg_ring_tracker
    import bsg_ring_tracker_pkg::*;
#(
    parameter int slots_p   = 8,
    parameter int max_enq_p = 2,
    parameter int max_deq_p = 2
)
(
    input  logic              clk,
    input  logic              reset_i,
    bsg_ring_tracker_if.slave ring
);

    localparam int ptr_width_lp = safe_clog2(slots_p);
    localparam int cnt_width_lp = count_width(slots_p);
    localparam int enq_width_lp = count_width(max_enq_p);
    localparam int deq_width_lp = count_width(max_deq_p);

    logic [cnt_width_lp-1:0] count_r;
    logic [cnt_width_lp-1:0] free_slots;
    logic [cnt_width_lp:0]   count_n;
    logic                    enq_accept;
    logic                    deq_accept;
    logic [enq_width_lp-1:0] wptr_add;
    logic [deq_width_lp-1:0] deq_add;
    logic [cnt_width_lp-1:0] rptr_add;
    logic [ptr_width_lp-1:0] wptr, rptr, wptr_n, rptr_n;

    assign free_slots = cnt_width_lp'(slots_p) - count_r;

    // Reset is folded in so nothing is reported accepted while held in reset.
    assign enq_accept = ring.enq_v_i & ~ring.flush_i & ~reset_i
                      & (cnt_width_lp'(ring.enq_cnt_i) <= free_slots);
    assign deq_accept = ring.deq_v_i & ~ring.flush_i & ~reset_i
                      & (cnt_width_lp'(ring.deq_cnt_i) <= count_r);

    assign wptr_add = enq_accept ? ring.enq_cnt_i : '0;
    assign deq_add  = deq_accept ? ring.deq_cnt_i : '0;

    // wptr == rptr + count (mod slots) always holds, so advancing rptr by
    // count_r lands it on wptr without a separate load path.
    assign rptr_add = ring.flush_i ? count_r : cnt_width_lp'(deq_add);

    assign count_n = (cnt_width_lp+1)'(count_r)
                   + (cnt_width_lp+1)'(wptr_add)
                   - (cnt_width_lp+1)'(deq_add);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (ring.flush_i) begin
            count_r <= '0;
        end else begin
            count_r <= count_n[cnt_width_lp-1:0];
        end
    end

    bsg_circular_ptr_ar #(.slots_p(slots_p), .max_add_p(max_enq_p)) wptr_ptr (
        .clk     (clk),
        .reset_i (reset_i),
        .add_i   (wptr_add),
        .ptr_o   (wptr),
        .ptr_n_o (wptr_n)
    );

    bsg_circular_ptr_ar #(.slots_p(slots_p), .max_add_p(slots_p)) rptr_ptr (
        .clk     (clk),
        .reset_i (reset_i),
        .add_i   (rptr_add),
        .ptr_o   (rptr),
        .ptr_n_o (rptr_n)
    );

    assign ring.enq_accept_o = enq_accept;
    assign ring.deq_accept_o = deq_accept;
    assign ring.wptr_o       = wptr;
    assign ring.rptr_o       = rptr;
    assign ring.count_o      = count_r;
    assign ring.full_o       = (count_r == cnt_width_lp'(slots_p));
    assign ring.empty_o      = (count_r == '0);

    // Simulation-only sanity checks; synthesis ignores concurrent assertions.
    a_count_range : assert property (@(posedge clk) disable iff (reset_i)
        count_r <= cnt_width_lp'(slots_p));
    a_count_next_range : assert property (@(posedge clk) disable iff (reset_i)
        count_n <= (cnt_width_lp+1)'(slots_p));
    a_enq_cnt_max : assert property (@(posedge clk) disable iff (reset_i)
        ring.enq_v_i |-> (ring.enq_cnt_i <= enq_width_lp'(max_enq_p)));
    a_deq_cnt_max : assert property (@(posedge clk) disable iff (reset_i)
        ring.deq_v_i |-> (ring.deq_cnt_i <= deq_width_lp'(max_deq_p)));
    a_ptr_next_range : assert property (@(posedge clk) disable iff (reset_i)
        (int'(wptr_n) < slots_p) && (int'(rptr_n) < slots_p));

endmodule
